mole_scheduler: RTL and testbench

- Parametrised next-generation mole selector for the Whak-a-Mole game.
- Picks one of N_HOLES holes using a free-running Galois LFSR and drives a one-hot mole output for a programmable up-time.
- Detects hits on the lit hole, counts score, and enforces a gap between moles.
- Sits between the button inputs and the display/LED memory path, replacing the fixed 4-hole press-driven counter.

---
 rtl/mole_pkg.sv | 22 ++
 rtl/mole_lfsr.sv | 26 ++
 rtl/mole_scheduler.sv | 168 ++++++++++++++++
 tb/tb_mole_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared state type, default LFSR constants and a width helper for the mole scheduler.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_UP,
    ST_GAP
  } state_t;

  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  // Index width for n holes; never below 1 so a 2-hole build still has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running Galois LFSR (right shift, XOR taps when a 1 falls out).
// A zero seed would lock the register at zero, so it is replaced by 1.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [LFSR_W-1:0] o_value
);

  localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= INIT;
    else       r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/mole_scheduler.sv
// Whak-a-Mole hole selector: random one-hot mole, timed up/gap windows, hit scoring.
// Optional MOLE_NO_REPEAT_EN: never light the same hole twice in a row within one game.
//   state | meaning
//   IDLE  | game stopped, outputs dark, score held
//   PICK  | one cycle, choose hole from LFSR and load up timer
//   UP    | mole lit, waiting for hit or timeout
//   GAP   | dark interval before the next pick
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int                N_HOLES = 4,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(DEF_SEED),
  parameter int                TIMER_W = 8,
  parameter int                SCORE_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [TIMER_W-1:0] i_up_cycles,
  input  logic [TIMER_W-1:0] i_gap_cycles,
  input  logic [N_HOLES-1:0] i_hit_in,
  output logic [N_HOLES-1:0] o_mole_out,
  output logic               o_hit_pulse,
  output logic               o_miss_pulse,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_busy
);

  localparam int                 IDX_W  = clog2(N_HOLES);
  localparam logic [IDX_W:0]     N_WIDE = (IDX_W+1)'(N_HOLES);
  localparam logic [N_HOLES-1:0] HOT0   = {{(N_HOLES-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic [IDX_W-1:0]   r_cur_idx, w_cur_idx_nxt;
  logic [N_HOLES-1:0] r_mole_out, w_mole_nxt;
  logic [N_HOLES-1:0] r_hit_prev, w_press;
  logic               r_hit_pulse, w_hit_nxt;
  logic               r_miss_pulse, w_miss_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [LFSR_W-1:0]  w_lfsr;
  logic [IDX_W:0]     w_raw, w_wrap;
  logic [IDX_W-1:0]   w_idx;
  logic [TIMER_W-1:0] w_up_load, w_gap_load;
  logic               w_unused;

  mole_lfsr #(
    .LFSR_W(LFSR_W),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_value(w_lfsr)
  );

  assign w_press    = i_hit_in & ~r_hit_prev;
  assign w_up_load  = (i_up_cycles  == '0) ? TIMER_W'(1) : i_up_cycles;
  assign w_gap_load = (i_gap_cycles == '0) ? TIMER_W'(1) : i_gap_cycles;

  // Raw index can exceed N_HOLES-1 by less than N_HOLES, so one subtract folds it back.
  assign w_raw    = {1'b0, w_lfsr[IDX_W-1:0]};
  assign w_wrap   = (w_raw >= N_WIDE) ? (w_raw - N_WIDE) : w_raw;
  assign w_unused = ^{w_lfsr[LFSR_W-1:IDX_W], w_wrap[IDX_W]};

`ifdef MOLE_NO_REPEAT_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HOLES - 1);
  logic r_prev_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_prev_valid <= 1'b0;
    else if (r_state == ST_IDLE) r_prev_valid <= 1'b0;
    else if (r_state == ST_PICK) r_prev_valid <= 1'b1;
  end

  always_comb begin
    w_idx = w_wrap[IDX_W-1:0];
    if (r_prev_valid && (w_idx == r_cur_idx))
      w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
  end
`else
  always_comb begin
    w_idx = w_wrap[IDX_W-1:0];
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_cur_idx_nxt = r_cur_idx;
    w_mole_nxt    = r_mole_out;
    w_score_nxt   = r_score;
    w_hit_nxt     = 1'b0;
    w_miss_nxt    = 1'b0;
    if (r_state == ST_IDLE) begin
      w_mole_nxt = '0;
      if (i_start) begin
        w_state_nxt = ST_PICK;
        w_score_nxt = '0;
      end
    end else if (!i_start) begin
      w_state_nxt = ST_IDLE;
      w_mole_nxt  = '0;
    end else begin
      case (r_state)
        ST_PICK: begin
          w_cur_idx_nxt = w_idx;
          w_mole_nxt    = HOT0 << w_idx;
          w_timer_nxt   = w_up_load;
          w_state_nxt   = ST_UP;
        end
        ST_UP: begin
          // A hit wins over a timeout landing on the same cycle.
          if (w_press[r_cur_idx]) begin
            w_hit_nxt   = 1'b1;
            w_score_nxt = (r_score == '1) ? r_score : r_score + 1'b1;
            w_mole_nxt  = '0;
            w_timer_nxt = w_gap_load;
            w_state_nxt = ST_GAP;
          end else if (r_timer <= TIMER_W'(1)) begin
            w_miss_nxt  = 1'b1;
            w_mole_nxt  = '0;
            w_timer_nxt = w_gap_load;
            w_state_nxt = ST_GAP;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_timer <= TIMER_W'(1)) w_state_nxt = ST_PICK;
          else                        w_timer_nxt = r_timer - 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_cur_idx    <= '0;
      r_mole_out   <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_score      <= '0;
      r_hit_prev   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_cur_idx    <= w_cur_idx_nxt;
      r_mole_out   <= w_mole_nxt;
      r_hit_pulse  <= w_hit_nxt;
      r_miss_pulse <= w_miss_nxt;
      r_score      <= w_score_nxt;
      r_hit_prev   <= i_hit_in;
    end
  end

  assign o_mole_out   = r_mole_out;
  assign o_hit_pulse  = r_hit_pulse;
  assign o_miss_pulse = r_miss_pulse;
  assign o_score      = r_score;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: a 4-hole and a 5-hole/3-bit-score instance, each shadowed by
// a game-level model checked every cycle, plus directed literal expectations.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] up0, gap0, up1, gap1;
  logic [3:0] hit0;
  logic [4:0] hit1;

  logic [3:0] mole0;
  logic       hitp0, missp0, busy0;
  logic [7:0] score0;
  logic [4:0] mole1;
  logic       hitp1, missp1, busy1;
  logic [2:0] score1;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  mole_scheduler #(.N_HOLES(4)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_up_cycles(up0), .i_gap_cycles(gap0),
    .i_hit_in(hit0), .o_mole_out(mole0), .o_hit_pulse(hitp0), .o_miss_pulse(missp0),
    .o_score(score0), .o_busy(busy0)
  );

  mole_scheduler #(.N_HOLES(5), .SCORE_W(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_up_cycles(up1), .i_gap_cycles(gap1),
    .i_hit_in(hit1), .o_mole_out(mole1), .o_hit_pulse(hitp1), .o_miss_pulse(missp1),
    .o_score(score1), .o_busy(busy1)
  );

  // Game-level model: a running flag, which hole is lit and for how long, how long it stays dark.
  typedef struct {
    bit          run;
    bit          pick_now;
    int          lit;
    int          lit_left;
    int          dark_left;
    int          last;
    int          score;
    bit          hit;
    bit          miss;
    logic [15:0] lfsr;
    logic [15:0] prev;
  } mdl_t;

  mdl_t m[2];
  int   n_of[2] = '{4, 5};
  int   smax[2] = '{255, 7};
  int   iw[2]   = '{2, 3};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset(input int k);
    m[k].run = 0; m[k].pick_now = 0; m[k].lit = -1; m[k].lit_left = 0;
    m[k].dark_left = 0; m[k].last = -1; m[k].score = 0; m[k].hit = 0; m[k].miss = 0;
    m[k].lfsr = 16'hACE1; m[k].prev = '0;
  endtask

  task automatic mstep(input int k, input bit st, input logic [15:0] hv, input int up, input int gap);
    logic [15:0] press;
    logic [15:0] cur;
    int raw;
    press = hv & ~m[k].prev;
    m[k].prev = hv;
    cur = m[k].lfsr;
    m[k].lfsr = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
    m[k].hit = 0;
    m[k].miss = 0;
    if (!m[k].run) begin
      if (st) begin m[k].run = 1; m[k].score = 0; m[k].pick_now = 1; end
    end else if (!st) begin
      m[k].run = 0; m[k].pick_now = 0; m[k].lit = -1; m[k].last = -1;
    end else if (m[k].pick_now) begin
      raw = int'(cur) % (1 << iw[k]);
      if (raw >= n_of[k]) raw -= n_of[k];
`ifdef MOLE_NO_REPEAT_EN
      if (raw == m[k].last) raw = (raw + 1) % n_of[k];
`endif
      m[k].last = raw;
      m[k].lit = raw;
      m[k].lit_left = (up == 0) ? 1 : up;
      m[k].pick_now = 0;
    end else if (m[k].lit >= 0) begin
      if (press[m[k].lit]) begin
        m[k].hit = 1;
        if (m[k].score < smax[k]) m[k].score++;
        m[k].lit = -1;
        m[k].dark_left = (gap == 0) ? 1 : gap;
      end else if (m[k].lit_left == 1) begin
        m[k].miss = 1;
        m[k].lit = -1;
        m[k].dark_left = (gap == 0) ? 1 : gap;
      end else begin
        m[k].lit_left--;
      end
    end else begin
      m[k].dark_left--;
      if (m[k].dark_left == 0) m[k].pick_now = 1;
    end
  endtask

  function automatic logic [31:0] exp_mole(input int k);
    return (m[k].lit >= 0) ? (32'd1 << m[k].lit) : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0, start0, {12'b0, hit0}, int'(up0), int'(gap0));
      mstep(1, start1, {11'b0, hit1}, int'(up1), int'(gap1));
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc0_mole",  32'(mole0),  exp_mole(0));
      chk("cyc0_hit",   32'(hitp0),  32'(m[0].hit));
      chk("cyc0_miss",  32'(missp0), 32'(m[0].miss));
      chk("cyc0_score", 32'(score0), 32'(m[0].score));
      chk("cyc0_busy",  32'(busy0),  32'(m[0].run));
      chk("cyc1_mole",  32'(mole1),  exp_mole(1));
      chk("cyc1_hit",   32'(hitp1),  32'(m[1].hit));
      chk("cyc1_miss",  32'(missp1), 32'(m[1].miss));
      chk("cyc1_score", 32'(score1), 32'(m[1].score));
      chk("cyc1_busy",  32'(busy1),  32'(m[1].run));
    end
  end

  function automatic bit mole_any(input int k);
    return (k == 0) ? (|mole0) : (|mole1);
  endfunction

  function automatic int idx_of(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Counts negedges while the lit/dark condition holds; bounded.
  task automatic count_lit(input int k, input bit want, output int n);
    n = 0;
    while ((mole_any(k) == want) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_bound: dut%0d stuck with lit=%0d, required a change within 1000 cycles", k, want);
    end
  endtask

  task automatic wait_mole_start(input int k);
    int n;
    count_lit(k, 1'b1, n);
    count_lit(k, 1'b0, n);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] h0;
  int n, found, repeats, prev_idx, cur_idx, bad1;
  int cnt1[5];

  initial begin
    rst = 1'b1; start0 = 0; start1 = 0; up0 = 8'd5; gap0 = 8'd3; up1 = 8'd5; gap1 = 8'd3;
    hit0 = '0; hit1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_mole0", 32'(mole0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_score0", 32'(score0), 0);
    chk("rst_pulses0", 32'({hitp0, missp0}), 0);
    chk("rst_mole1", 32'(mole1), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    start0 = 1; start1 = 1;
    @(negedge clk);
    chk("lat_busy", 32'(busy0), 1);
    chk("lat_mole", 32'(mole0), 0);
    @(negedge clk);
    // Seed ACE1 after 4 steps is 1C4E: low 2 bits = 2; low 3 bits = 6 -> 6-5 = 1.
    chk("first_pick0", 32'(mole0), 32'h4);
    chk("first_pick1", 32'(mole1), 32'h2);
    chk("model_pick0", 32'(m[0].lit), 2);

    count_lit(0, 1'b1, n);
    chk("up_len", 32'(n), 5);
    chk("timeout_miss", 32'(missp0), 1);
    chk("timeout_score", 32'(score0), 0);
    count_lit(0, 1'b0, n);
    // gap interval of 3 plus the one-cycle pick
    chk("dark_len", 32'(n), 4);

    @(negedge clk);
    h0 = mole0;
    hit0 = h0;
    @(negedge clk);
    chk("hit_pulse", 32'(hitp0), 1);
    chk("hit_score", 32'(score0), 1);
    chk("hit_clear", 32'(mole0), 0);
    chk("hit_nomiss", 32'(missp0), 0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      wait_mole_start(0);
      if (mole0 == h0) found = 1;
    end
    chk("held_found", 32'(found), 1);
    count_lit(0, 1'b1, n);
    chk("held_len", 32'(n), 5);
    chk("held_miss", 32'(missp0), 1);
    chk("held_score", 32'(score0), 1);
    hit0 = '0;

    wait_mole_start(0);
    h0 = mole0;
    hit0 = {h0[2:0], h0[3]};
    @(negedge clk);
    chk("wrong_mole", 32'(mole0), 32'(h0));
    chk("wrong_hit", 32'(hitp0), 0);
    hit0 = '0;
    repeat (3) @(negedge clk);
    chk("tie_lit", 32'(mole0), 32'(h0));
    hit0 = h0;
    @(negedge clk);
    chk("tie_hit", 32'(hitp0), 1);
    chk("tie_miss", 32'(missp0), 0);
    chk("tie_score", 32'(score0), 2);
    hit0 = '0;

    wait_mole_start(0);
    @(negedge clk);
    start0 = 0;
    hit0 = mole0;
    @(negedge clk);
    chk("stop_busy", 32'(busy0), 0);
    chk("stop_mole", 32'(mole0), 0);
    chk("stop_score", 32'(score0), 2);
    chk("stop_pulses", 32'({hitp0, missp0}), 0);
    hit0 = '0;
    @(negedge clk);
    chk("stop_idle", 32'(busy0), 0);

    up0 = 8'd0; gap0 = 8'd0; start0 = 1;
    @(negedge clk);
    chk("restart_score", 32'(score0), 0);
    wait_mole_start(0);
    count_lit(0, 1'b1, n);
    chk("up_zero_len", 32'(n), 1);
    count_lit(0, 1'b0, n);
    chk("gap_zero_dark", 32'(n), 2);
    repeats = 0;
    prev_idx = -1;
    for (int i = 0; i < 1000; i++) begin
      cur_idx = idx_of({12'b0, mole0});
      if (cur_idx == prev_idx) repeats++;
      prev_idx = cur_idx;
      count_lit(0, 1'b1, n);
      count_lit(0, 1'b0, n);
    end
`ifdef MOLE_NO_REPEAT_EN
    chk("no_repeat", 32'(repeats), 0);
`endif
    start0 = 0;

    up1 = 8'd0; gap1 = 8'd0;
    bad1 = 0;
    for (int i = 0; i < 5; i++) cnt1[i] = 0;
    wait_mole_start(1);
    for (int i = 0; i < 2000; i++) begin
      if (!$onehot(mole1)) bad1++;
      else cnt1[idx_of({11'b0, mole1})]++;
      count_lit(1, 1'b1, n);
      count_lit(1, 1'b0, n);
    end
    chk("n5_onehot_bad", 32'(bad1), 0);
    for (int i = 0; i < 5; i++) chk("n5_hole_used", 32'(cnt1[i] > 0), 1);

    up1 = 8'd4; gap1 = 8'd1;
    for (int i = 1; i <= 10; i++) begin
      wait_mole_start(1);
      hit1 = mole1;
      @(negedge clk);
      chk("sat_hit", 32'(hitp1), 1);
      if (i == 7) chk("sat_at7", 32'(score1), 7);
      hit1 = '0;
    end
    chk("sat_score", 32'(score1), 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
